mem_access: RTL

- Memory-access stage directly downstream of the execute stage.
- Registers execute outputs into an internal EX/MEM register and drives a single-outstanding data-memory request/ready handshake.
- Formats store byte lanes and load sign/zero extension, then registers results into a MEM/WB register for writeback.
- Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_access_if.sv | 24 ++
 rtl/mem_access.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/ready bus between the memory-access stage and the data memory.
// Single outstanding request; the master holds all request fields stable until ready.
interface mem_access_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     req;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [3:0]               be;
    logic                     ready;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: EX/MEM register, single-outstanding data-memory handshake,
// store lane formatting, load extension and MEM/WB register.
module mem_access #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write_e,
    input  logic [1:0]               res_src_e,
    input  logic                     mem_write_e,
    input  logic [2:0]               funct3_e,
    input  logic [DATA_WIDTH-1:0]    alu_result_e,
    input  logic [DATA_WIDTH-1:0]    write_data_e,
    input  logic [4:0]               rd_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    input  logic                     flush_m,
    mem_access_if.master             dmem,
    output logic [DATA_WIDTH-1:0]    alu_result_m,
    output logic [4:0]               rd_m,
    output logic                     reg_write_m,
    output logic                     stall_m,
    output logic                     misaligned_m,
    output logic                     reg_write_w,
    output logic [1:0]               res_src_w,
    output logic [DATA_WIDTH-1:0]    alu_result_w,
    output logic [DATA_WIDTH-1:0]    read_data_w,
    output logic [4:0]               rd_w,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_w
);

    typedef enum logic {ST_RUN, ST_WAIT} state_e;

    typedef struct packed {
        logic                     reg_write;
        logic [1:0]               res_src;
        logic                     mem_write;
        logic [2:0]               funct3;
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    write_data;
        logic [4:0]               rd;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
    } ex_mem_t;

    typedef struct packed {
        logic                     reg_write;
        logic [1:0]               res_src;
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    read_data;
        logic [4:0]               rd;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
    } mem_wb_t;

    state_e  state_q, state_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;
    logic    misaligned_q, misaligned_d;

    logic                  is_load;
    logic                  mem_op;
    logic                  misaligned;
    logic                  aligned_op;
    logic [1:0]            lane;
    logic [3:0]            store_be;
    logic [DATA_WIDTH-1:0] store_wdata;
    logic [DATA_WIDTH-1:0] rdata_shifted;
    logic [DATA_WIDTH-1:0] load_data;

    always_comb begin
        lane       = ex_mem_q.alu_result[1:0];
        is_load    = (ex_mem_q.res_src == 2'b01);
        mem_op     = ex_mem_q.mem_write | is_load;
        misaligned = ((ex_mem_q.funct3[1:0] == 2'b01) && lane[0]) ||
                     ((ex_mem_q.funct3[1:0] == 2'b10) && (lane != 2'b00));
        aligned_op = mem_op & ~misaligned;
    end

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = ex_mem_q.write_data;
        case (ex_mem_q.funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << lane;
                store_wdata = {4{ex_mem_q.write_data[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << {lane[1], 1'b0};
                store_wdata = {2{ex_mem_q.write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Halfword loads are always at lane 0 or 2 once aligned, so one byte-granular shift serves both sizes.
    always_comb begin
        rdata_shifted = dmem.rdata >> {lane, 3'b000};
        case (ex_mem_q.funct3)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            ex_mem_q     <= '0;
            mem_wb_q     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ex_mem_q     <= ex_mem_d;
            mem_wb_q     <= mem_wb_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (aligned_op && !dmem.ready) state_d = ST_WAIT;
            ST_WAIT: if (dmem.ready) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        dmem.req   = 1'b0;
        stall_m    = 1'b0;
        dmem.we    = 1'b0;
        dmem.addr  = '0;
        dmem.be    = '0;
        dmem.wdata = '0;
        case (state_q)
            ST_RUN: begin
                dmem.req = aligned_op;
                stall_m  = aligned_op & ~dmem.ready;
            end
            ST_WAIT: begin
                dmem.req = 1'b1;
                stall_m  = ~dmem.ready;
            end
            default: ;
        endcase
        // EX/MEM is frozen while stalled, so the request fields stay stable without extra holding flops.
        if (dmem.req) begin
            dmem.we    = ex_mem_q.mem_write;
            dmem.addr  = {ex_mem_q.alu_result[ADDRESS_WIDTH-1:2], 2'b00};
            dmem.be    = ex_mem_q.mem_write ? store_be : 4'b1111;
            dmem.wdata = ex_mem_q.mem_write ? store_wdata : '0;
        end
    end

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!stall_m) begin
            ex_mem_d.reg_write  = reg_write_e;
            ex_mem_d.res_src    = res_src_e;
            ex_mem_d.mem_write  = mem_write_e;
            ex_mem_d.funct3     = funct3_e;
            ex_mem_d.alu_result = alu_result_e;
            ex_mem_d.write_data = write_data_e;
            ex_mem_d.rd         = rd_e;
            ex_mem_d.pc_plus4   = pc_plus4_e;
            if (flush_m) begin
                ex_mem_d.reg_write = 1'b0;
                ex_mem_d.mem_write = 1'b0;
                ex_mem_d.res_src   = 2'b00;
                ex_mem_d.rd        = 5'd0;
            end
        end
    end

    always_comb begin
        mem_wb_d     = '0;
        misaligned_d = mem_op & misaligned;
        if (!stall_m && !(mem_op && misaligned)) begin
            mem_wb_d.reg_write  = ex_mem_q.reg_write;
            mem_wb_d.res_src    = ex_mem_q.res_src;
            mem_wb_d.alu_result = ex_mem_q.alu_result;
            mem_wb_d.read_data  = is_load ? load_data : '0;
            mem_wb_d.rd         = ex_mem_q.rd;
            mem_wb_d.pc_plus4   = ex_mem_q.pc_plus4;
        end
    end

    always_comb begin
        alu_result_m = ex_mem_q.alu_result;
        rd_m         = ex_mem_q.rd;
        reg_write_m  = ex_mem_q.reg_write;
        misaligned_m = misaligned_q;
        reg_write_w  = mem_wb_q.reg_write;
        res_src_w    = mem_wb_q.res_src;
        alu_result_w = mem_wb_q.alu_result;
        read_data_w  = mem_wb_q.read_data;
        rd_w         = mem_wb_q.rd;
        pc_plus4_w   = mem_wb_q.pc_plus4;
    end

endmodule
